// File: rtl/speech_frame_runner_pkg.sv
// Shared codec2 definitions for the multi-frame analysis driver:
// FSM encoding, LSP count, result-word select codes and default widths.
package speech_frame_runner_pkg;

   localparam int DEF_N  = 32;
   localparam int DEF_Q  = 16;

   localparam int NLSP   = 10;
   // One energy word followed by the LSPs
   localparam int NWORDS = NLSP + 1;

   localparam logic [3:0] SEL_E    = 4'd0;
   localparam logic [3:0] SEL_LSP0 = 4'd1;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LAUNCH  = 3'd1,
      S_RUN     = 3'd2,
      S_CAPTURE = 3'd3,
      S_ADVANCE = 3'd4,
      S_DONE    = 3'd5,
      S_ERROR   = 3'd6
   } state_t;

endpackage

// File: rtl/speech_frame_runner_lsp_result_bank.sv
// Per-frame result store: NFRAMES x (energy + 10 LSPs) words.
// One 11-word parallel write port, one combinational read port.
// Out-of-range frame or word selects read as zero.
module speech_frame_runner_lsp_result_bank
   import speech_frame_runner_pkg::*;
#(
   parameter int N       = DEF_N,
   parameter int NFRAMES = 4,
   parameter int FW      = (NFRAMES > 1) ? $clog2(NFRAMES) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_we,
   input  logic [FW-1:0]    i_wr_frame,
   input  logic [N-1:0]     i_wr_e,
   input  logic [NLSP*N-1:0] i_wr_lsp,
   input  logic [FW-1:0]    i_rd_frame,
   input  logic [3:0]       i_rd_sel,
   output logic [N-1:0]     o_rd_data
);

   logic [N-1:0] r_bank [NFRAMES][NWORDS];
   logic [N-1:0] w_rd_data;

   // Clear on reset; otherwise capture one frame's energy and LSPs at once
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int f = 0; f < NFRAMES; f++) begin
            for (int w = 0; w < NWORDS; w++) begin
               r_bank[f][w] <= '0;
            end
         end
      end else if (i_we && (int'(i_wr_frame) < NFRAMES)) begin
         r_bank[i_wr_frame][SEL_E] <= i_wr_e;
         for (int k = 0; k < NLSP; k++) begin
            r_bank[i_wr_frame][int'(SEL_LSP0) + k] <= i_wr_lsp[k*N +: N];
         end
      end
   end

   // Combinational read with zero for unused selects
   always_comb begin
      w_rd_data = '0;
      if ((int'(i_rd_frame) < NFRAMES) && (int'(i_rd_sel) < NWORDS)) begin
         w_rd_data = r_bank[i_rd_frame][i_rd_sel];
      end
   end

   assign o_rd_data = w_rd_data;

endmodule

// File: rtl/speech_frame_runner.sv
// Multi-frame driver for the speech_to_uq_lsps core. One start pulse runs
// the core over NFRAMES frames, offsetting its sample addresses by a
// per-frame base, enforcing a per-frame watchdog and banking each frame's
// energy and LSPs.
//
// Handshake: start is a level sampled only in IDLE/DONE/ERROR; core_start is
// a one-cycle pulse; core_done is a one-cycle strobe honoured only in RUN,
// and core_e/core_lsp must still be valid in the cycle after core_done.
module speech_frame_runner
   import speech_frame_runner_pkg::*;
#(
   parameter int N         = DEF_N,
   parameter int Q         = DEF_Q,
   parameter int AW        = 10,
   parameter int NFRAMES   = 4,
   parameter int FRAME_ADV = 80,
   parameter int TIMEOUT   = 200000,
   localparam int FDW      = $clog2(NFRAMES + 1),
   localparam int FW       = (NFRAMES > 1) ? $clog2(NFRAMES) : 1,
   localparam int WDW      = $clog2(TIMEOUT + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              timeout_err,
   output logic [FDW-1:0]    frames_done,
   output logic [AW-1:0]     mem_addr,
   input  logic [N-1:0]      mem_rdata,
   output logic              core_start,
   input  logic              core_done,
   input  logic [AW-1:0]     core_addr,
   output logic [N-1:0]      core_sample,
   input  logic [N-1:0]      core_e,
   input  logic [NLSP*N-1:0] core_lsp,
   input  logic [FW-1:0]     rd_frame,
   input  logic [3:0]        rd_sel,
   output logic [N-1:0]      rd_data,
   output logic [2:0]        dbg_state
);

   state_t           r_state;
   logic             r_busy;
   logic             r_done;
   logic             r_timeout_err;
   logic             r_core_start;
   logic [FDW-1:0]   r_frames_done;
   logic [AW-1:0]    r_mem_addr;
   logic [N-1:0]     r_core_sample;
   logic [AW-1:0]    r_base;
   logic [WDW-1:0]   r_wdog;

   logic             w_bank_we;
   logic [FW-1:0]    w_bank_frame;

   // Run sequencer: launch, relay samples, capture, advance base, finish
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= S_IDLE;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
         r_timeout_err <= 1'b0;
         r_core_start  <= 1'b0;
         r_frames_done <= '0;
         r_mem_addr    <= '0;
         r_core_sample <= '0;
         r_base        <= '0;
         r_wdog        <= '0;
      end else begin
         r_core_start <= 1'b0;
         case (r_state)
            // A new run looks the same from rest, completion or failure
            S_IDLE, S_DONE, S_ERROR: begin
               if (start) begin
                  r_state       <= S_LAUNCH;
                  r_frames_done <= '0;
                  r_base        <= '0;
                  r_wdog        <= '0;
                  r_done        <= 1'b0;
                  r_timeout_err <= 1'b0;
                  r_busy        <= 1'b1;
                  r_core_start  <= 1'b1;
               end
            end
            S_LAUNCH: begin
               r_state <= S_RUN;
            end
            // Two-cycle sample path: address register, then RAM, then sample register
            S_RUN: begin
               r_mem_addr    <= r_base + core_addr;
               r_core_sample <= mem_rdata;
               r_wdog        <= r_wdog + WDW'(1);
               if (core_done) begin
                  r_state <= S_CAPTURE;
               end else if (r_wdog == WDW'(TIMEOUT - 1)) begin
                  r_state       <= S_ERROR;
                  r_busy        <= 1'b0;
                  r_timeout_err <= 1'b1;
               end
            end
            S_CAPTURE: begin
               r_frames_done <= r_frames_done + FDW'(1);
               r_state       <= S_ADVANCE;
            end
            S_ADVANCE: begin
               r_wdog <= '0;
               if (r_frames_done == FDW'(NFRAMES)) begin
                  r_state <= S_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end else begin
                  r_base       <= r_base + AW'(FRAME_ADV);
                  r_state      <= S_LAUNCH;
                  r_core_start <= 1'b1;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign w_bank_we    = (r_state == S_CAPTURE);
   assign w_bank_frame = r_frames_done[FW-1:0];

   speech_frame_runner_lsp_result_bank #(
      .N       (N),
      .NFRAMES (NFRAMES),
      .FW      (FW)
   ) u_lsp_result_bank (
      .clk        (clk),
      .rst        (rst),
      .i_we       (w_bank_we),
      .i_wr_frame (w_bank_frame),
      .i_wr_e     (core_e),
      .i_wr_lsp   (core_lsp),
      .i_rd_frame (rd_frame),
      .i_rd_sel   (rd_sel),
      .o_rd_data  (rd_data)
   );

   assign busy        = r_busy;
   assign done        = r_done;
   assign timeout_err = r_timeout_err;
   assign core_start  = r_core_start;
   assign frames_done = r_frames_done;
   assign mem_addr    = r_mem_addr;
   assign core_sample = r_core_sample;
   assign dbg_state   = r_state;

endmodule
